// File: rtl/async_fifo_wr_ctrl.sv
// rtl/async_fifo_wr_ctrl.sv - write-side controller of an asynchronous FIFO
// Optional fill-level output and almost-full logic enabled by macro WFIFO_LEVEL_EN.
module async_fifo_wr_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_TH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   rd_ptr_gray,
  input  logic              ovf_clr,
  output logic              wr_ram_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic              full,
  output logic              almost_full,
`ifdef WFIFO_LEVEL_EN
  output logic              overflow,
  output logic [ADDR_W:0]   wr_level
`else
  output logic              overflow
`endif
);

  logic            accept;
  logic [ADDR_W:0] wbin_q, wbin_d;
  logic [ADDR_W:0] wgray_q, wgray_d;
  logic            full_q, full_d;
  logic            overflow_q, overflow_d;
  logic [ADDR_W:0] sync_q [SYNC_STAGES];
  logic [ADDR_W:0] sync_d [SYNC_STAGES];
  logic [ADDR_W:0] rq_sync;

  assign rq_sync = sync_q[SYNC_STAGES-1];

  // Write acceptance, next pointers, full detection against the synchronized read pointer.
  always_comb begin
    accept  = wr_en & ~full_q;
    wbin_d  = wbin_q + {{ADDR_W{1'b0}}, accept};
    wgray_d = wbin_d ^ (wbin_d >> 1);
    // Full when the pointers differ only in the two Gray MSBs (one full lap apart).
    full_d  = (wgray_d == {~rq_sync[ADDR_W:ADDR_W-1], rq_sync[ADDR_W-2:0]});
    // A new overflow event outranks a clear issued on the same edge.
    overflow_d = (wr_en & full_q) | (overflow_q & ~ovf_clr);
  end

  // Shift chain carrying the foreign-domain read pointer into clk.
  always_comb begin
    sync_d[0] = rd_ptr_gray;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Pointer, flag and synchronizer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q     <= '0;
      wgray_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      wbin_q     <= wbin_d;
      wgray_q    <= wgray_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign wr_ram_we   = accept;
  assign wr_addr     = wbin_q[ADDR_W-1:0];
  assign wr_ptr_gray = wgray_q;
  assign full        = full_q;
  assign overflow    = overflow_q;

`ifdef WFIFO_LEVEL_EN
  localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W+1)'((2 ** ADDR_W) - AFULL_TH);

  logic [ADDR_W:0] rbin_s;
  logic [ADDR_W:0] wr_level_q, wr_level_d;
  logic            almost_full_q, almost_full_d;

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    for (int i = 0; i <= ADDR_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  // Fill level seen from the write side; pessimistic because rbin_s lags the reader.
  always_comb begin
    rbin_s        = gray2bin(rq_sync);
    wr_level_d    = wbin_d - rbin_s;
    almost_full_d = (wr_level_d >= AFULL_LVL);
  end

  // Level and almost-full registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_level_q    <= '0;
      almost_full_q <= 1'b0;
    end else begin
      wr_level_q    <= wr_level_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign wr_level    = wr_level_q;
  assign almost_full = almost_full_q;
`else
  logic unused_afull_cfg;
  assign unused_afull_cfg = (AFULL_TH != 0);
  assign almost_full      = 1'b0;
`endif

endmodule
